// File: rtl/prbs_checker.sv
// prbs_checker: PRBS-7 / PRBS-13 receive checker with lock acquisition, loss-of-lock
// detection and saturating bit/error statistics.
//
// Ports:
//   clock     - sole clock, rising edge
//   reset     - synchronous active-high reset
//   control   - pattern select: 0 = PRBS-7 (x^7+x^6+1), 1 = PRBS-13 (x^13+x^12+x^2+x+1)
//   rx_bit    - received serial bit, qualified by rx_valid
//   rx_valid  - rx_bit qualifier
//   clear     - synchronous clear of the statistics counters only
//   locked    - high while in the LOCKED state
//   bit_count - bits checked while locked (saturating)
//   err_count - bit errors detected while locked (saturating)
//   err_pulse - one-cycle pulse per locked-mode mismatch
//   first_err_pos / first_err_valid - bit_count value at the first locked-mode error;
//               present only when PRBS_CHK_FIRST_ERR_EN is defined.
module prbs_checker #(
    parameter int unsigned LOCK_CNT = 32,
    parameter int unsigned LOSS_WIN = 64,
    parameter int unsigned LOSS_THR = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        control,
    input  logic        rx_bit,
    input  logic        rx_valid,
    input  logic        clear,
`ifdef PRBS_CHK_FIRST_ERR_EN
    output logic [31:0] first_err_pos,
    output logic        first_err_valid,
`endif
    output logic        locked,
    output logic [31:0] bit_count,
    output logic [15:0] err_count,
    output logic        err_pulse
);

    localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WinW   = $clog2(LOSS_WIN + 1);

    typedef enum logic [1:0] {StHunt, StCheck, StLocked} state_e;

    state_e              state_q, state_d;
    logic [12:0]         s_q, s_d;
    logic [3:0]          fill_q, fill_d;
    logic [MatchW-1:0]   match_q, match_d;
    logic [WinW-1:0]     win_bits_q, win_bits_d;
    logic [WinW-1:0]     win_errs_q, win_errs_d;
    logic [31:0]         bit_count_q, bit_count_d;
    logic [15:0]         err_count_q, err_count_d;
    logic                err_pulse_q, err_pulse_d;
    logic                locked_q, locked_d;
    logic                ctrl_q, ctrl_d;
`ifdef PRBS_CHK_FIRST_ERR_EN
    logic [31:0]         first_pos_q, first_pos_d;
    logic                first_vld_q, first_vld_d;
`endif

    logic                pred;
    logic                mism;
    logic                active_nz;
    logic [3:0]          fill_last;
    logic [31:0]         bit_count_inc;
    logic [WinW-1:0]     win_bits_inc;
    logic [WinW-1:0]     win_errs_inc;

    always_comb begin
        pred          = control ? (s_q[12] ^ s_q[11] ^ s_q[1] ^ s_q[0]) : (s_q[6] ^ s_q[5]);
        mism          = rx_bit ^ pred;
        // An all-zero register predicts zeros forever, so matches there prove nothing.
        active_nz     = control ? (|s_q) : (|s_q[6:0]);
        fill_last     = control ? 4'd12 : 4'd6;
        bit_count_inc = (bit_count_q == '1) ? bit_count_q : bit_count_q + 32'd1;
        win_bits_inc  = win_bits_q + 1'b1;
        win_errs_inc  = win_errs_q + WinW'(mism);
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_bits_d  = win_bits_q;
        win_errs_d  = win_errs_q;
        bit_count_d = bit_count_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        ctrl_d      = control;
`ifdef PRBS_CHK_FIRST_ERR_EN
        first_pos_d = first_pos_q;
        first_vld_d = first_vld_q;
`endif

        if (control != ctrl_q) begin
            // Pattern switch: restart acquisition, keep statistics.
            state_d    = StHunt;
            fill_d     = '0;
            match_d    = '0;
            win_bits_d = '0;
            win_errs_d = '0;
        end else if (rx_valid) begin
            unique case (state_q)
                StHunt: begin
                    s_d = {s_q[11:0], rx_bit};
                    if (fill_q == fill_last) begin
                        state_d = StCheck;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 4'd1;
                    end
                end
                StCheck: begin
                    s_d = {s_q[11:0], rx_bit};
                    if (mism) begin
                        match_d = '0;
                    end else if (active_nz) begin
                        if (match_q == MatchW'(LOCK_CNT - 1)) begin
                            state_d = StLocked;
                            match_d = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end
                end
                StLocked: begin
                    // Shift the prediction so a received error cannot corrupt later ones.
                    s_d         = {s_q[11:0], pred};
                    bit_count_d = bit_count_inc;
                    if (mism) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 16'd1;
                        end
`ifdef PRBS_CHK_FIRST_ERR_EN
                        if (!first_vld_q) begin
                            first_pos_d = bit_count_inc;
                            first_vld_d = 1'b1;
                        end
`endif
                    end
                    if (win_bits_inc == WinW'(LOSS_WIN)) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                        if (win_errs_inc >= WinW'(LOSS_THR)) begin
                            state_d = StHunt;
                            fill_d  = '0;
                        end
                    end else begin
                        win_bits_d = win_bits_inc;
                        win_errs_d = win_errs_inc;
                    end
                end
                default: state_d = StHunt;
            endcase
        end

        if (clear) begin
            bit_count_d = '0;
            err_count_d = '0;
            win_bits_d  = '0;
            win_errs_d  = '0;
`ifdef PRBS_CHK_FIRST_ERR_EN
            first_pos_d = '0;
            first_vld_d = 1'b0;
`endif
        end

        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StHunt;
            s_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            bit_count_q <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
            // Track the current select so leaving reset is not seen as a switch.
            ctrl_q      <= control;
`ifdef PRBS_CHK_FIRST_ERR_EN
            first_pos_q <= '0;
            first_vld_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_bits_q  <= win_bits_d;
            win_errs_q  <= win_errs_d;
            bit_count_q <= bit_count_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
            ctrl_q      <= ctrl_d;
`ifdef PRBS_CHK_FIRST_ERR_EN
            first_pos_q <= first_pos_d;
            first_vld_q <= first_vld_d;
`endif
        end
    end

    assign locked    = locked_q;
    assign bit_count = bit_count_q;
    assign err_count = err_count_q;
    assign err_pulse = err_pulse_q;
`ifdef PRBS_CHK_FIRST_ERR_EN
    assign first_err_pos   = first_pos_q;
    assign first_err_valid = first_vld_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: self-checking bench for prbs_checker. A vector table drives locked
// runs with error bursts; hand-written sequences cover reset, all-zero input, clear,
// rx_valid gaps, mode change, random data and (optionally) first-error capture.
`timescale 1ns/1ps
module tb_prbs_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        control = 1'b0;
    logic        rx_bit = 1'b0;
    logic        rx_valid = 1'b0;
    logic        clear = 1'b0;
    logic        locked;
    logic [31:0] bit_count;
    logic [15:0] err_count;
    logic        err_pulse;
`ifdef PRBS_CHK_FIRST_ERR_EN
    logic [31:0] first_err_pos;
    logic        first_err_valid;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [12:0] g;
    int          pulses;

    always #5 clock = ~clock;

    prbs_checker dut (
        .clock     (clock),
        .reset     (reset),
        .control   (control),
        .rx_bit    (rx_bit),
        .rx_valid  (rx_valid),
        .clear     (clear),
`ifdef PRBS_CHK_FIRST_ERR_EN
        .first_err_pos  (first_err_pos),
        .first_err_valid(first_err_valid),
`endif
        .locked    (locked),
        .bit_count (bit_count),
        .err_count (err_count),
        .err_pulse (err_pulse)
    );

    typedef struct {
        logic mode;
        int   b1_start;
        int   b1_len;
        int   b2_start;
        int   b2_len;
        int   nbits;
        int   exp_lock_at;
        int   exp_fall_at;
        logic exp_locked;
        int   exp_bits;
        int   exp_errs;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic v);
        rx_bit   = b;
        rx_valid = v;
        @(posedge clock);
        #1;
        if (err_pulse === 1'b1) pulses++;
    endtask

    // Reference generator: next bit from the polynomial recurrence over past bits.
    task automatic gen(output logic b);
        b = control ? (g[12] ^ g[11] ^ g[1] ^ g[0]) : (g[6] ^ g[5]);
        g = {g[11:0], b};
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        clear    = 1'b0;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        g      = 13'h1;
        pulses = 0;
    endtask

    // Feeds the clean stream until locked; 0 means no lock within the budget.
    task automatic run_to_lock(output int lock_at);
        logic b;
        lock_at = 0;
        for (int i = 1; i <= 200 && lock_at == 0; i++) begin
            gen(b);
            step(b, 1'b1);
            if (locked === 1'b1) lock_at = i;
        end
    endtask

    vec_t vecs[5];

    initial begin
        logic b;
        logic r;
        logic v;
        logic flip;
        int   lock_at;
        int   fall_at;
        int   accepted;
        int   errs;
        bit   ever_locked;

        vecs[0] = '{1'b0,   0, 0,   0, 0, 1000, 39,   0, 1'b1, 1000,  0};
        vecs[1] = '{1'b1, 100, 1, 200, 1,  300, 45,   0, 1'b1,  300,  2};
        vecs[2] = '{1'b0,   1, 7,  65, 8,  128, 39, 128, 1'b0,  128, 15};
        vecs[3] = '{1'b1,  57, 8,   0, 0,   64, 45,  64, 1'b0,   64,  8};
        vecs[4] = '{1'b0,  60, 7,   0, 0,  200, 39,   0, 1'b1,  200,  7};

        // Reset state
        control = 1'b0;
        do_reset();
        check("reset locked", 32'(locked), 32'd0);
        check("reset bit_count", bit_count, 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);
        check("reset err_pulse", 32'(err_pulse), 32'd0);

        // Table-driven locked runs with error bursts
        for (int t = 0; t < 5; t++) begin
            control = vecs[t].mode;
            do_reset();
            run_to_lock(lock_at);
            check($sformatf("v%0d lock_at", t), 32'(lock_at), 32'(vecs[t].exp_lock_at));
            pulses  = 0;
            fall_at = 0;
            for (int k = 1; k <= vecs[t].nbits; k++) begin
                gen(b);
                flip = (k >= vecs[t].b1_start && k < vecs[t].b1_start + vecs[t].b1_len) ||
                       (k >= vecs[t].b2_start && k < vecs[t].b2_start + vecs[t].b2_len);
                step(b ^ flip, 1'b1);
                if (flip) check($sformatf("v%0d err_pulse@%0d", t, k), 32'(err_pulse), 32'd1);
                if (locked !== 1'b1 && fall_at == 0) fall_at = k;
            end
            check($sformatf("v%0d fall_at", t), 32'(fall_at), 32'(vecs[t].exp_fall_at));
            check($sformatf("v%0d locked", t), 32'(locked), 32'(vecs[t].exp_locked));
            check($sformatf("v%0d bit_count", t), bit_count, 32'(vecs[t].exp_bits));
            check($sformatf("v%0d err_count", t), 32'(err_count), 32'(vecs[t].exp_errs));
            check($sformatf("v%0d pulses", t), 32'(pulses), 32'(vecs[t].exp_errs));
        end

        // All-zero input never locks
        control = 1'b0;
        do_reset();
        ever_locked = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1);
            if (locked !== 1'b0) ever_locked = 1'b1;
        end
        check("zeros ever_locked", 32'(ever_locked), 32'd0);
        check("zeros bit_count", bit_count, 32'd0);
        check("zeros err_count", 32'(err_count), 32'd0);

        // rx_valid gaps, clear, reset and relock
        control = 1'b0;
        do_reset();
        run_to_lock(lock_at);
        check("gap lock_at", 32'(lock_at), 32'd39);
        accepted = 0;
        for (int i = 0; i < 200; i++) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                gen(b);
                step(b ^ (accepted == 20), 1'b1);
                accepted++;
            end else begin
                step(1'($urandom_range(0, 1)), 1'b0);
                check("gap bit_count hold", bit_count, 32'(accepted));
            end
        end
        check("gap bit_count", bit_count, 32'(accepted));
        check("gap err_count", 32'(err_count), 32'(accepted > 20 ? 1 : 0));
        check("gap locked", 32'(locked), 32'd1);
        clear = 1'b1;
        gen(b);
        step(b, 1'b1);
        clear = 1'b0;
        check("clear bit_count", bit_count, 32'd0);
        check("clear err_count", 32'(err_count), 32'd0);
        check("clear locked", 32'(locked), 32'd1);
        for (int i = 0; i < 10; i++) begin
            gen(b);
            step(b, 1'b1);
        end
        check("post-clear bit_count", bit_count, 32'd10);
        reset = 1'b1;
        clear = 1'b1;
        gen(b);
        step(b, 1'b1);
        reset = 1'b0;
        clear = 1'b0;
        check("mid-lock reset locked", 32'(locked), 32'd0);
        check("mid-lock reset bit_count", bit_count, 32'd0);
        run_to_lock(lock_at);
        check("relock lock_at", 32'(lock_at), 32'd39);

        // Mode change while locked: back to hunt, statistics held
        for (int i = 0; i < 20; i++) begin
            gen(b);
            step(b, 1'b1);
        end
        check("pre-switch bit_count", bit_count, 32'd20);
        control = 1'b1;
        step(1'b0, 1'b0);
        check("switch locked", 32'(locked), 32'd0);
        check("switch bit_count hold", bit_count, 32'd20);
        g = 13'h1;
        run_to_lock(lock_at);
        check("switch lock_at", 32'(lock_at), 32'd45);
        check("switch relock bit_count", bit_count, 32'd20);

        // Locked PRBS-7 followed by random data
        control = 1'b0;
        do_reset();
        run_to_lock(lock_at);
        errs    = 0;
        fall_at = 0;
        for (int k = 1; k <= 64; k++) begin
            gen(b);
            r = 1'($urandom_range(0, 1));
            if (r != b) errs++;
            step(r, 1'b1);
            if (locked !== 1'b1 && fall_at == 0) fall_at = k;
        end
        check("random fall_at", 32'(fall_at), 32'(errs >= 8 ? 64 : 0));
        check("random err_count", 32'(err_count), 32'(errs));

`ifdef PRBS_CHK_FIRST_ERR_EN
        // First-error capture
        control = 1'b0;
        do_reset();
        run_to_lock(lock_at);
        for (int k = 1; k <= 80; k++) begin
            gen(b);
            step(b ^ (k == 50 || k == 70), 1'b1);
        end
        check("first_err_pos", first_err_pos, 32'd50);
        check("first_err_valid", 32'(first_err_valid), 32'd1);
        clear = 1'b1;
        gen(b);
        step(b, 1'b1);
        clear = 1'b0;
        check("first_err_valid clear", 32'(first_err_valid), 32'd0);
        check("first_err_pos clear", first_err_pos, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_CNT, default 32: consecutive predicted-bit matches required to declare lock.
REQ-002 Parameter LOSS_WIN, default 64: locked-mode error window length in bits.
REQ-003 Parameter LOSS_THR, default 8: errors within one window that force loss of lock.
REQ-004 clock  input  1  sole clock; all logic updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 control  input  1  pattern select: 0 = PRBS-7 (x^7+x^6+1), 1 = PRBS-13 (x^13+x^12+x^2+x+1).
REQ-007 rx_bit  input  1  received serial data bit.
REQ-008 rx_valid  input  1  rx_bit qualifier; the block ignores cycles with rx_valid=0.
REQ-009 clear  input  1  synchronous clear of statistics counters only.
REQ-010 locked  output  1  high while in LOCKED state.
REQ-011 bit_count  output  32  bits checked while locked.
REQ-012 err_count  output  16  bit errors detected while locked.
REQ-013 err_pulse  output  1  one-cycle pulse for each locked-mode mismatch.

Function
REQ-014 Shift register s[12:0]; each accepted bit shifts in at s[0]; predicted bit p = s[6]^s[5] (PRBS-7) or s[12]^s[11]^s[1]^s[0] (PRBS-13).
REQ-015 States HUNT, CHECK, LOCKED; a state transition and counter update occur only on cycles with rx_valid=1, except for reset, clear and mode change.
REQ-016 HUNT: shift in rx_bit; after N accepted bits (N=7 or 13) go to CHECK with match counter 0.
REQ-017 CHECK: shift in rx_bit (self-synchronising); match with non-zero active register increments match counter; mismatch zeroes it; reaching LOCK_CNT goes to LOCKED in that cycle.
REQ-018 CHECK: a match while the active N register bits are all zero does not increment the match counter (an all-zero stream never locks).
REQ-019 LOCKED: shift in p, not rx_bit (errors do not propagate); each accepted bit increments bit_count; rx_bit!=p increments err_count and asserts err_pulse on the next cycle.
REQ-020 LOCKED: window counters track bits and errors; when the window bit count reaches LOSS_WIN and window errors >= LOSS_THR, go to HUNT; otherwise both window counters restart at 0.
REQ-021 locked is registered and reflects the state after each update; bit_count and err_count outputs are registered, latency 1 cycle from the accepted bit.
REQ-022 bit_count and err_count saturate at all-ones and never wrap.
REQ-023 clear=1: bit_count=0, err_count=0, window counters=0 in the next cycle; the state and shift register are unaffected; clear has priority over a simultaneous increment.
REQ-024 A change of control between consecutive cycles forces HUNT with fill counter 0; the statistics counters hold their values.
REQ-025 The counters do not change in HUNT or CHECK.

Reset
REQ-026 reset=1: state=HUNT, s=0, all internal counters=0, locked=0, bit_count=0, err_count=0, err_pulse=0 on the next edge; reset overrides clear, rx_valid and mode change.
REQ-027 Reset mid-lock discards the lock; relock requires the full HUNT+CHECK sequence.

Configuration
REQ-028 Macro PRBS_CHK_FIRST_ERR_EN defined: output first_err_pos [31:0] holds the bit_count value at the first locked-mode error since reset or clear, plus 1-bit first_err_valid; both are cleared by reset and clear.
REQ-029 Macro PRBS_CHK_FIRST_ERR_EN undefined: these ports and their logic are absent; all other behaviour is identical.

Verification
REQ-030 PRBS-7 error-free stream, rx_valid=1 continuous: locked rises on accepted bit 7+32=39; after 1000 further bits, bit_count=1000 and err_count=0.
REQ-031 PRBS-13 locked stream with single bit flips at locked bits 100 and 200: err_count=2, two err_pulse pulses, locked remains 1.
REQ-032 Locked PRBS-7 stream followed by random data: locked falls at the first window end with >=8 errors.
REQ-033 All-zero input with control=0: locked stays 0 indefinitely; counters stay 0.
REQ-034 Locked stream with clear pulsed, then reset pulsed, with rx_valid toggled randomly: clear zeroes the counts while locked stays 1; reset drops locked; gaps with rx_valid=0 leave all values unchanged.
REQ-035 With PRBS_CHK_FIRST_ERR_EN defined, first error injected at locked bit 50: first_err_pos=50, first_err_valid=1, and later errors leave first_err_pos unchanged.
